// File: rtl/riscv_pkg.sv
// Shared RV32M encodings and constants for the EX-stage multiply/divide unit.
package riscv_pkg;

  // funct3 encodings of the M-extension ops
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Most negative value: dividend of the signed-overflow case and its DIV result
  localparam logic [31:0] DIV_OVF_Q = 32'h8000_0000;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: 2*XLEN shift register plus a shared adder/subtractor.
// Works on unsigned magnitudes; one shift-add (multiply) or restoring
// shift-subtract (divide) step per enabled cycle. acc_nxt is the value the
// register takes on the next step, so the owner can use the final step's
// result in the same cycle.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_nxt
);

  // acc_q = {hi, lo}: multiply keeps {partial product, multiplier},
  // divide keeps {partial remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     shi;
  logic [XLEN:0]     diff;

  // One iteration of shift-add or restoring shift-subtract
  always_comb begin
    sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    shi  = acc_q[2*XLEN-1:XLEN-1];
    diff = shi - {1'b0, opb_q};
    if (!is_div) begin
      acc_nxt = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      acc_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = {acc_q[2*XLEN-2:0], 1'b0};
    end
  end

  // Operand load on start, then advance one step per enable
  always_ff @(posedge clk) begin
    if (load) begin
      acc_q <= {{XLEN{1'b0}}, opa};
      opb_q <= opb;
    end else if (step) begin
      acc_q <= acc_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle RV32M multiply/divide unit. Owns the control FSM,
// operand sign handling, the single-cycle special cases and final sign fixup.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiplies).
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      stall,
  input  logic            flush,
  input  logic            ex_start,
  input  logic [2:0]      ex_op,
  input  logic [XLEN-1:0] ex_DataA,
  input  logic [XLEN-1:0] ex_DataB,
  output logic            stall_req,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  muldiv_op_e        op_q, op_d, op_in;
  logic              neg_q, neg_d;
  logic              sa_q, sa_d;
  logic              valid_d;
  logic [XLEN-1:0]   result_d;
  logic              load, step, stall_req_c;
  logic              is_div, sa, sb, b_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc_nxt;
  logic              unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  // Negate the magnitude product if needed and pick the requested half
  function automatic logic [XLEN-1:0] fix_mul(input logic [2*XLEN-1:0] p,
                                              input logic neg, input logic hi);
    logic [2*XLEN-1:0] pp;
    pp = neg ? -p : p;
    return hi ? pp[2*XLEN-1:XLEN] : pp[XLEN-1:0];
  endfunction

  // Quotient negated when signs differ; remainder follows the dividend
  function automatic logic [XLEN-1:0] fix_div(input logic [XLEN-1:0] q,
                                              input logic [XLEN-1:0] r,
                                              input logic qneg, input logic rneg,
                                              input logic rem);
    if (rem) return rneg ? -r : r;
    return qneg ? -q : q;
  endfunction

  // Decode op signedness and form operand magnitudes
  always_comb begin
    op_in  = muldiv_op_e'(ex_op);
    is_div = ex_op[2];
    sa     = 1'b0;
    sb     = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin
        sa = ex_DataA[XLEN-1];
        sb = ex_DataB[XLEN-1];
      end
      OP_MULHSU: sa = ex_DataA[XLEN-1];
      default: ;
    endcase
    mag_a   = sa ? -ex_DataA : ex_DataA;
    mag_b   = sb ? -ex_DataB : ex_DataB;
    b_zero  = (ex_DataB == '0);
    div_ovf = (op_in == OP_DIV || op_in == OP_REM) &&
              (ex_DataA == DIV_OVF_Q) && (ex_DataB == '1);
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk     (clk),
    .load    (load),
    .step    (step),
    .is_div  (op_q[2]),
    .opa     (mag_a),
    .opb     (mag_b),
    .acc_nxt (acc_nxt)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  // Next-state, datapath control and stall request
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_d        = op_q;
    neg_d       = neg_q;
    sa_d        = sa_q;
    valid_d     = 1'b0;
    result_d    = md_result;
    load        = 1'b0;
    step        = 1'b0;
    stall_req_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_start) begin
          stall_req_c = 1'b1;
          op_d        = op_in;
          neg_d       = sa ^ sb;
          sa_d        = sa;
          if (is_div && b_zero) begin
            result_d = ex_op[1] ? ex_DataA : '1;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = ex_op[1] ? '0 : DIV_OVF_Q;
            valid_d  = 1'b1;
            state_d  = DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div) begin
            result_d = fix_mul(fast_prod, sa ^ sb, op_in != OP_MUL);
            valid_d  = 1'b1;
            state_d  = DONE;
`endif
          end else begin
            load    = 1'b1;
            count_d = CNT_W'(XLEN);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_req_c = 1'b1;
        step        = 1'b1;
        if (count_q == CNT_W'(1)) begin
          result_d = op_q[2] ?
                     fix_div(acc_nxt[XLEN-1:0], acc_nxt[2*XLEN-1:XLEN], neg_q, sa_q, op_q[1]) :
                     fix_mul(acc_nxt, neg_q, op_q != OP_MUL);
          valid_d  = 1'b1;
          count_d  = '0;
          state_d  = DONE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (stall[4]) begin
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      count_d     = '0;
      valid_d     = 1'b0;
      load        = 1'b0;
      step        = 1'b0;
      stall_req_c = 1'b0;
    end
  end

  assign stall_req = stall_req_c & rst_n;

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      sa_q      <= 1'b0;
      md_valid  <= 1'b0;
      md_result <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      sa_q      <= sa_d;
      md_valid  <= valid_d;
      md_result <= result_d;
    end
  end

endmodule
